aibcr3_tx_dly_align: RTL and testbench

- Transmit-side counterpart to the RX DCC delay mimic.
- Takes 40-bit core TX data (ihssi_tx_data_in) and launches it through a programmable-depth register pipeline. The pipeline adds one extra stage whenever the DCC path is active (not bypassed), so TX latency tracks the RX mimic.
- Derives the DCC-bypass select with the same CSR/DLL/DPRIO rule the RX side uses.
- Blanks output data and valid for a fixed settle window after reset or any latency-config change.

---
 rtl/aibcr3_tx_dly_align_if.sv | 33 +++
 rtl/aibcr3_tx_dly_align.sv | 163 ++++++++++++++++
 tb/tb_aibcr3_tx_dly_align.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aibcr3_tx_dly_align_if.sv
// ----------------------------------------------------------------------------
// aibcr3_tx_dly_align_if
//   Bundles the core-side TX data path of aibcr3_tx_dly_align.
//   master : core side (drives data/valid in, observes delayed data/valid)
//   slave  : delay-align block (consumes data/valid in, drives delayed outputs)
// Signals:
//   ihssi_tx_data_in      [DWIDTH] core TX data
//   ihssi_tx_data_vld     [1]      valid qualifier travelling with the data
//   ihssi_tx_data_out_dly [DWIDTH] delayed TX data (0 while settling)
//   tx_data_vld_out       [1]      delayed valid (0 while settling)
// ----------------------------------------------------------------------------
interface aibcr3_tx_dly_align_if #(
   parameter int DWIDTH = 40
);
   logic [DWIDTH-1:0] ihssi_tx_data_in;
   logic              ihssi_tx_data_vld;
   logic [DWIDTH-1:0] ihssi_tx_data_out_dly;
   logic              tx_data_vld_out;

   modport master (
      output ihssi_tx_data_in,
      output ihssi_tx_data_vld,
      input  ihssi_tx_data_out_dly,
      input  tx_data_vld_out
   );

   modport slave (
      input  ihssi_tx_data_in,
      input  ihssi_tx_data_vld,
      output ihssi_tx_data_out_dly,
      output tx_data_vld_out
   );
endinterface

// File: rtl/aibcr3_tx_dly_align.sv
// ----------------------------------------------------------------------------
// aibcr3_tx_dly_align
//   Transmit-side latency matcher for the RX DCC delay mimic. Core TX data is
//   launched through a register pipeline whose tap depth is
//      L = 1 + dly_sel + (DCC active ? 1 : 0)
//   so TX latency follows the RX mimic. Output data/valid are blanked for
//   SETTLE_CYC cycles after reset release or any latency-config change.
// Ports:
//   tx_clk            in   TX core clock, rising edge
//   tx_rst            in   synchronous active-high reset
//   tx_if             slave  data/valid in, delayed data/valid out
//   csr_reg6          in   1: DLL controls bypass, 0: DPRIO controls bypass
//   idll_core2dll_1   in   DLL bypass request (async)
//   rb_dcc_byp_dprio  in   DPRIO DCC enable, bypass is its inverse (async)
//   rb_tx_dly_sel     in   extra delay stages (quasi-static, clamped to MAXSEL)
//   dcc_byp_mux_q     out  synchronized bypass select (1 = DCC bypassed)
//   tx_dly_settling   out  high while outputs are blanked
// ----------------------------------------------------------------------------
module aibcr3_tx_dly_align #(
   parameter int DWIDTH     = 40,
   parameter int MAXSEL     = 3,
   parameter int SETTLE_CYC = 8
) (
   input  logic                       tx_clk,
   input  logic                       tx_rst,
   aibcr3_tx_dly_align_if.slave       tx_if,
   input  logic                       csr_reg6,
   input  logic                       idll_core2dll_1,
   input  logic                       rb_dcc_byp_dprio,
   input  logic [1:0]                 rb_tx_dly_sel,
   output logic                       dcc_byp_mux_q,
   output logic                       tx_dly_settling
);

   localparam int DEPTH = MAXSEL + 2;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam int CW    = $clog2(SETTLE_CYC);
   localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);
   localparam logic [1:0]    SEL_MAX  = 2'(MAXSEL);

   typedef enum logic {
      SETTLE,
      RUN
   } state_t;

   // bypass synchronizer
   logic byp_raw;
   logic byp_sync1_q, byp_sync1_d;
   logic dcc_byp_mux_d;

   // latency config
   logic [1:0] dly_sel_q, dly_sel_d;
   logic [2:0] cfg;
   logic [2:0] cfg_d1_q, cfg_d1_d;
   logic       chg;

   // data/valid pipeline, stage 1 holds the most recent sample
   logic [DEPTH:1][DWIDTH-1:0] pipe_q, pipe_d;
   logic [DEPTH:1]             vld_q,  vld_d;
   logic [LW-1:0]              lat;
   logic [DWIDTH-1:0]          tap_data;
   logic                       tap_vld;

   // settle FSM
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // -------------------------------------------------------------------------
   // Bypass select and config tracking
   // -------------------------------------------------------------------------
   always_comb begin
      byp_raw       = csr_reg6 ? idll_core2dll_1 : ~rb_dcc_byp_dprio;
      byp_sync1_d   = byp_raw;
      dcc_byp_mux_d = byp_sync1_q;

      if (int'(rb_tx_dly_sel) > MAXSEL) begin
         dly_sel_d = SEL_MAX;
      end else begin
         dly_sel_d = rb_tx_dly_sel;
      end

      cfg      = {dcc_byp_mux_q, dly_sel_q};
      cfg_d1_d = cfg;
      chg      = (cfg != cfg_d1_q);
   end

   // -------------------------------------------------------------------------
   // Pipeline shift (unconditional, valid rides alongside data)
   // -------------------------------------------------------------------------
   always_comb begin
      pipe_d = {pipe_q[DEPTH-1:1], tx_if.ihssi_tx_data_in};
      vld_d  = {vld_q[DEPTH-1:1],  tx_if.ihssi_tx_data_vld};
   end

   // -------------------------------------------------------------------------
   // Tap select: stage L holds the word sampled L-1 edges before the latest
   // -------------------------------------------------------------------------
   always_comb begin
      lat      = LW'(dly_sel_q) + (dcc_byp_mux_q ? LW'(1) : LW'(2));
      tap_data = '0;
      tap_vld  = 1'b0;
      for (int unsigned i = 1; i <= DEPTH; i++) begin
         if (lat == LW'(i)) begin
            tap_data = pipe_q[i];
            tap_vld  = vld_q[i];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Settle FSM: a config change always reloads the window, even mid-window
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      if (chg) begin
         state_d = SETTLE;
         cnt_d   = CNT_INIT;
      end else if (state_q == SETTLE) begin
         if (cnt_q == '0) begin
            state_d = RUN;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end

      tx_dly_settling = (state_q == SETTLE);
      if (state_q == RUN) begin
         tx_if.ihssi_tx_data_out_dly = tap_data;
         tx_if.tx_data_vld_out       = tap_vld;
      end else begin
         tx_if.ihssi_tx_data_out_dly = '0;
         tx_if.tx_data_vld_out       = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         byp_sync1_q   <= 1'b0;
         dcc_byp_mux_q <= 1'b0;
         dly_sel_q     <= '0;
         cfg_d1_q      <= '0;
         pipe_q        <= '0;
         vld_q         <= '0;
         state_q       <= SETTLE;
         cnt_q         <= CNT_INIT;
      end else begin
         byp_sync1_q   <= byp_sync1_d;
         dcc_byp_mux_q <= dcc_byp_mux_d;
         dly_sel_q     <= dly_sel_d;
         cfg_d1_q      <= cfg_d1_d;
         pipe_q        <= pipe_d;
         vld_q         <= vld_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
      end
   end

endmodule

// File: tb/tb_aibcr3_tx_dly_align.sv
// ----------------------------------------------------------------------------
// tb_aibcr3_tx_dly_align
//   Self-checking bench for aibcr3_tx_dly_align: a reset/ramp vector table,
//   hand-written sequences for config changes, bypass, reload, mid-stream
//   reset and valid patterns, then randomized traffic. Every edge is also
//   checked against a sample-history reference model.
// ----------------------------------------------------------------------------
module tb_aibcr3_tx_dly_align;
   localparam int DW     = 40;
   localparam int MAXSEL = 3;
   localparam int SETTLE = 8;
   localparam int DEPTH  = MAXSEL + 2;

   logic       tx_clk = 1'b0;
   logic       tx_rst;
   logic       csr_reg6, idll, dprio;
   logic [1:0] sel;
   logic       dcc_byp_mux_q, tx_dly_settling;

   aibcr3_tx_dly_align_if #(.DWIDTH(DW)) tx_if ();

   aibcr3_tx_dly_align #(
      .DWIDTH    (DW),
      .MAXSEL    (MAXSEL),
      .SETTLE_CYC(SETTLE)
   ) dut (
      .tx_clk          (tx_clk),
      .tx_rst          (tx_rst),
      .tx_if           (tx_if.slave),
      .csr_reg6        (csr_reg6),
      .idll_core2dll_1 (idll),
      .rb_dcc_byp_dprio(dprio),
      .rb_tx_dly_sel   (sel),
      .dcc_byp_mux_q   (dcc_byp_mux_q),
      .tx_dly_settling (tx_dly_settling)
   );

   always #5 tx_clk = ~tx_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[0] is the word sampled at the latest edge; output with latency L is
   // hist[L-1]. Settling is "fewer than SETTLE edges since the last event".
   typedef struct packed {
      logic [DW-1:0] d;
      logic          v;
   } smp_t;

   smp_t hist[$];
   logic m_raw_prev = 1'b0;
   logic m_byp      = 1'b0;
   int   m_sel      = 0;
   int   cur_cfg    = 0;
   int   prev_cfg   = 0;
   int   k          = 0;
   int   last_evt   = 0;

   task automatic model_edge();
      logic raw_now;
      k++;
      raw_now = csr_reg6 ? idll : ~dprio;
      if (tx_rst) begin
         hist.delete();
         for (int i = 0; i < DEPTH; i++) hist.push_back('0);
         m_raw_prev = 1'b0;
         m_byp      = 1'b0;
         m_sel      = 0;
         cur_cfg    = 0;
         prev_cfg   = 0;
         last_evt   = k;
      end else begin
         // a config value seen on the outputs differs from its predecessor
         if (cur_cfg != prev_cfg) last_evt = k;
         hist.push_front({tx_if.ihssi_tx_data_in, tx_if.ihssi_tx_data_vld});
         void'(hist.pop_back());
         m_byp      = m_raw_prev;
         m_raw_prev = raw_now;
         m_sel      = (int'(sel) > MAXSEL) ? MAXSEL : int'(sel);
         prev_cfg   = cur_cfg;
         cur_cfg    = (m_byp ? 8 : 0) + m_sel;
      end
   endtask

   task automatic step();
      int   lat;
      smp_t e;
      logic s;
      @(posedge tx_clk);
      model_edge();
      #1;
      s   = ((k - last_evt) < SETTLE);
      lat = 1 + m_sel + (m_byp ? 0 : 1);
      e   = s ? smp_t'('0) : hist[lat-1];
      chk("model_settling", 64'(tx_dly_settling), 64'(s));
      chk("model_byp", 64'(dcc_byp_mux_q), 64'(m_byp));
      chk("model_data", 64'(tx_if.ihssi_tx_data_out_dly), 64'(e.d));
      chk("model_vld", 64'(tx_if.tx_data_vld_out), 64'(e.v));
   endtask

   task automatic drive(input logic [DW-1:0] d, input logic v);
      tx_if.ihssi_tx_data_in  = d;
      tx_if.ihssi_tx_data_vld = v;
   endtask

   logic [DW-1:0] ramp;

   task automatic ramp_step();
      drive(ramp, 1'b1);
      step();
      ramp++;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          rst;
      logic [DW-1:0] d;
      logic          v;
      logic [DW-1:0] ed;
      logic          ev;
      logic          es;
   } vec_t;

   vec_t          tbl[11];
   int            n;
   logic          seen_aa;
   logic [DW-1:0] pat_d[4];
   logic          pat_v[4];
   logic [DW-1:0] obs_d[8];
   logic          obs_v[8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_rst   = 1'b1;
      csr_reg6 = 1'b0;
      idll     = 1'b0;
      dprio    = 1'b1;
      sel      = 2'd0;
      drive('0, 1'b0);

      // row 0 is the reset edge; rows 1..7 are blanked; from row 8 the ramp
      // appears with L=2 (word from the previous edge)
      for (int r = 0; r < 11; r++) begin
         tbl[r].rst = (r == 0);
         tbl[r].d   = (r == 0) ? '0 : DW'(r);
         tbl[r].v   = (r != 0);
         tbl[r].ed  = (r >= 8) ? DW'(r - 1) : '0;
         tbl[r].ev  = (r >= 8);
         tbl[r].es  = (r < 8);
      end

      for (int r = 0; r < 11; r++) begin
         tx_rst = tbl[r].rst;
         drive(tbl[r].d, tbl[r].v);
         step();
         chk("tbl_data", 64'(tx_if.ihssi_tx_data_out_dly), 64'(tbl[r].ed));
         chk("tbl_vld", 64'(tx_if.tx_data_vld_out), 64'(tbl[r].ev));
         chk("tbl_settling", 64'(tx_dly_settling), 64'(tbl[r].es));
         chk("tbl_byp", 64'(dcc_byp_mux_q), 64'(0));
      end

      ramp = 40'd11;
      repeat (3) ramp_step();
      chk("ramp_L2", 64'(tx_if.ihssi_tx_data_out_dly), 64'(ramp - 40'd2));

      // dly_sel 0 -> 3: registered on the first edge, window from the second
      sel = 2'd3;
      ramp_step();
      chk("sel3_first_edge", 64'(tx_dly_settling), 64'(0));
      ramp_step();
      chk("sel3_settle", 64'(tx_dly_settling), 64'(1));
      chk("sel3_blank", 64'(tx_if.ihssi_tx_data_out_dly), 64'(0));
      n = 0;
      while (tx_dly_settling && n < 30) begin
         n++;
         ramp_step();
      end
      chk("sel3_window", 64'(n), 64'(8));
      chk("sel3_L5", 64'(tx_if.ihssi_tx_data_out_dly), 64'(ramp - 40'd5));

      // DLL-controlled bypass
      csr_reg6 = 1'b1;
      repeat (2) ramp_step();
      chk("csr_no_change", 64'(tx_dly_settling), 64'(0));
      idll = 1'b1;
      ramp_step();
      chk("byp_edge1", 64'(dcc_byp_mux_q), 64'(0));
      ramp_step();
      chk("byp_edge2", 64'(dcc_byp_mux_q), 64'(1));
      ramp_step();
      n = 0;
      while (tx_dly_settling && n < 30) begin
         n++;
         ramp_step();
      end
      chk("byp_window", 64'(n), 64'(8));
      chk("byp_L4", 64'(tx_if.ihssi_tx_data_out_dly), 64'(ramp - 40'd4));

      // second change lands while the counter is at 2
      sel = 2'd1;
      ramp_step();
      chk("reload_first_edge", 64'(tx_dly_settling), 64'(0));
      for (int i = 0; i < 5; i++) begin
         ramp_step();
         chk("reload_settle", 64'(tx_dly_settling), 64'(1));
      end
      sel = 2'd2;
      n = 0;
      ramp_step();
      while (tx_dly_settling && n < 30) begin
         n++;
         ramp_step();
      end
      chk("reload_window", 64'(n), 64'(9));
      chk("reload_L3", 64'(tx_if.ihssi_tx_data_out_dly), 64'(ramp - 40'd3));

      // one-cycle reset with 0xAA words in flight
      drive(40'hAA_AAAA_AAAA, 1'b1);
      repeat (3) step();
      tx_rst = 1'b1;
      step();
      chk("rst_data", 64'(tx_if.ihssi_tx_data_out_dly), 64'(0));
      chk("rst_vld", 64'(tx_if.tx_data_vld_out), 64'(0));
      chk("rst_settling", 64'(tx_dly_settling), 64'(1));
      chk("rst_byp", 64'(dcc_byp_mux_q), 64'(0));
      tx_rst  = 1'b0;
      seen_aa = 1'b0;
      for (int i = 0; i < 40; i++) begin
         ramp_step();
         if (tx_if.ihssi_tx_data_out_dly == 40'hAA_AAAA_AAAA) seen_aa = 1'b1;
      end
      chk("rst_no_aa", 64'(seen_aa), 64'(0));

      // sel=2 with DCC active, valid pattern 1,0,1,1 (L=4)
      csr_reg6 = 1'b0;
      dprio    = 1'b1;
      sel      = 2'd2;
      repeat (3) ramp_step();
      n = 0;
      while (tx_dly_settling && n < 40) begin
         n++;
         ramp_step();
      end
      chk("vldpat_settled", 64'(tx_dly_settling), 64'(0));
      pat_v[0] = 1'b1; pat_v[1] = 1'b0; pat_v[2] = 1'b1; pat_v[3] = 1'b1;
      for (int i = 0; i < 4; i++) pat_d[i] = 40'h12_3456_7800 + DW'(i);
      for (int t = 0; t < 8; t++) begin
         if (t < 4) drive(pat_d[t], pat_v[t]);
         else       drive(40'hFF_FFFF_FF00 + DW'(t), 1'b0);
         step();
         obs_d[t] = tx_if.ihssi_tx_data_out_dly;
         obs_v[t] = tx_if.tx_data_vld_out;
      end
      for (int i = 0; i < 4; i++) begin
         chk("vldpat_vld", 64'(obs_v[i+3]), 64'(pat_v[i]));
         chk("vldpat_data", 64'(obs_d[i+3]), 64'(pat_d[i]));
      end

      // randomized traffic and config churn
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) csr_reg6 = ~csr_reg6;
         if ($urandom_range(0, 9) == 0)  idll = ~idll;
         if ($urandom_range(0, 29) == 0) dprio = ~dprio;
         tx_rst = ($urandom_range(0, 99) == 0);
         drive({8'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
         step();
      end
      tx_rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
